decode_feed_queue: RTL and testbench

Parametrised instruction feeder for the decode stage of the LC-3 pipeline. It buffers up to DEPTH instruction/PSR entries, each carrying its own bubble count, and drives instr_dout, npc_in, psr and en_decode into decode at up to one instruction per cycle. NPC is tracked internally and stall, flush and run control are supported. It replaces the fixed, task-driven decode stimulus with synthesizable, cycle-accurate sequencing used both in the stage-level bench and in system bring-up.

---
 rtl/decode_feed_queue.sv | 149 ++++++++++++++
 tb/tb_decode_feed_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_feed_queue.sv
// decode_feed_queue: buffered instruction/PSR feeder for the LC-3 decode stage.
// Entries wait in a circular FIFO, each with its own bubble count, and are
// issued one per cycle at most with a locally tracked NPC.
module decode_feed_queue #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 16,
  parameter int PSR_W   = 3,
  parameter int DEPTH   = 8,
  parameter int GAP_W   = 4,
  parameter logic [ADDR_W-1:0] RESET_NPC = 16'h3000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push_valid,
  output logic                         push_ready,
  input  logic [INSTR_W-1:0]           push_instr,
  input  logic [PSR_W-1:0]             push_psr,
  input  logic [GAP_W-1:0]             push_gap,
  input  logic                         run,
  input  logic                         stall_in,
  input  logic                         flush,
  input  logic [ADDR_W-1:0]            flush_npc,
  output logic [INSTR_W-1:0]           instr_dout,
  output logic [ADDR_W-1:0]            npc_in,
  output logic [PSR_W-1:0]             psr,
  output logic                         en_decode,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [15:0]                  issue_count,
  output logic                         idle
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [GAP_W-1:0]  GAP_ONE  = GAP_W'(1);
  localparam logic [ADDR_W-1:0] NPC_ONE  = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, GAP, ISSUE} state_t;

  state_t state, state_nxt;

  logic [INSTR_W-1:0] mem_instr [DEPTH];
  logic [PSR_W-1:0]   mem_psr   [DEPTH];
  logic [GAP_W-1:0]   mem_gap   [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic             push_acc, can_pop, pop, complete;

  // Full is judged from the registered count only, so a same-cycle pop never frees a slot early.
  assign push_ready = (count != CNT_FULL);
  assign push_acc   = push_valid && push_ready && !flush;
  assign can_pop    = run && (count != '0);

  // State register; reset and flush both return to IDLE.
  always_ff @(posedge clock) begin
    if (reset || flush) state <= IDLE;
    else                state <= state_nxt;
  end

  // Next-state logic plus the pop/complete strobes that drive the datapath.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        if (can_pop) begin
          pop       = 1'b1;
          state_nxt = (mem_gap[rd_ptr] == '0) ? ISSUE : GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_ONE) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (!stall_in) begin
          complete = 1'b1;
          if (can_pop) begin
            pop       = 1'b1;
            state_nxt = (mem_gap[rd_ptr] == '0) ? ISSUE : GAP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode-facing status derived from the current state.
  always_comb begin
    en_decode = (state == ISSUE);
    idle      = (state == IDLE) && (count == '0);
  end

  // Queue storage is written only on accepted pushes and needs no reset.
  always_ff @(posedge clock) begin
    if (push_acc) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_psr[wr_ptr]   <= push_psr;
      mem_gap[wr_ptr]   <= push_gap;
    end
  end

  // Pointers, occupancy, output registers, NPC and issue counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      instr_dout  <= '0;
      psr         <= '0;
      gap_cnt     <= '0;
      npc_in      <= RESET_NPC;
      issue_count <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      instr_dout <= '0;
      psr        <= '0;
      gap_cnt    <= '0;
      npc_in     <= flush_npc;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        instr_dout <= mem_instr[rd_ptr];
        psr        <= mem_psr[rd_ptr];
        gap_cnt    <= mem_gap[rd_ptr];
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_ONE;
      end
      case ({push_acc, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (complete) begin
        npc_in      <= npc_in + NPC_ONE;
        issue_count <= issue_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_decode_feed_queue.sv
// Directed bench for decode_feed_queue with an issue scoreboard.
module tb_decode_feed_queue;

  logic        clock = 1'b0;
  logic        reset, push_valid, run, stall_in, flush;
  logic [15:0] push_instr, flush_npc;
  logic [2:0]  push_psr;
  logic [3:0]  push_gap;
  logic        push_ready, en_decode, idle;
  logic [15:0] instr_dout, npc_in, issue_count;
  logic [2:0]  psr;
  logic [3:0]  count;

  typedef struct {
    logic [15:0] instr;
    logic [2:0]  psr;
  } ent_t;

  ent_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_npc;
  logic [15:0] exp_issues;
  logic [15:0] hold_npc;
  logic [4:0]  pat;

  decode_feed_queue dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready),
    .push_instr(push_instr), .push_psr(push_psr), .push_gap(push_gap),
    .run(run), .stall_in(stall_in), .flush(flush), .flush_npc(flush_npc),
    .instr_dout(instr_dout), .npc_in(npc_in), .psr(psr),
    .en_decode(en_decode), .count(count),
    .issue_count(issue_count), .idle(idle)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A completing issue is visible mid-cycle: en_decode high and no stall/flush/reset.
  task automatic monitor();
    ent_t e;
    if (reset === 1'b0 && flush === 1'b0 && en_decode === 1'b1 && stall_in === 1'b0) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("issue_instr", 32'(instr_dout), 32'(e.instr));
        check("issue_psr", 32'(psr), 32'(e.psr));
        check("issue_npc", 32'(npc_in), 32'(exp_npc));
        exp_npc++;
        exp_issues++;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [15:0] i, input logic [2:0] p, input logic [3:0] g);
    ent_t e;
    push_valid = 1'b1;
    push_instr = i;
    push_psr   = p;
    push_gap   = g;
    e.instr = i;
    e.psr   = p;
    sb.push_back(e);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      tick();
      if (idle === 1'b1 && sb.size() == 0) done = 1'b1;
    end
    check("wait_idle", 32'(done), 32'd1);
  endtask

  initial begin
    reset = 1'b1; push_valid = 1'b0; run = 1'b0; stall_in = 1'b0; flush = 1'b0;
    push_instr = '0; push_psr = '0; push_gap = '0; flush_npc = '0;
    exp_npc = 16'h3000; exp_issues = '0;
    tick(); tick();
    check("rst_instr", 32'(instr_dout), 32'h0);
    check("rst_npc", 32'(npc_in), 32'h3000);
    check("rst_psr", 32'(psr), 32'h0);
    check("rst_en", 32'(en_decode), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_issues", 32'(issue_count), 32'h0);
    check("rst_ready", 32'(push_ready), 32'h1);
    check("rst_idle", 32'(idle), 32'h1);
    reset = 1'b0;

    // Three back-to-back gap-0 entries
    run = 1'b1;
    push(16'h1234, 3'd1, 4'd0);
    check("lat_en0", 32'(en_decode), 32'h0);
    check("lat_count", 32'(count), 32'h1);
    push(16'h5678, 3'd2, 4'd0);
    check("b2b_en1", 32'(en_decode), 32'h1);
    push(16'h9ABC, 3'd3, 4'd0);
    check("b2b_en2", 32'(en_decode), 32'h1);
    tick();
    check("b2b_en3", 32'(en_decode), 32'h1);
    tick();
    check("b2b_en_off", 32'(en_decode), 32'h0);
    check("b2b_idle", 32'(idle), 32'h1);
    check("b2b_npc", 32'(npc_in), 32'h3003);
    check("b2b_issues", 32'(issue_count), 32'(exp_issues));

    // Gap of three bubbles
    push(16'h1111, 3'd4, 4'd3);
    pat = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pat = {pat[3:0], en_decode};
    end
    check("gap_pattern", 32'(pat), 32'b00010);
    check("gap_issues", 32'(issue_count), 32'(exp_issues));

    // Stall held four cycles in ISSUE
    push(16'h2222, 3'd5, 4'd0);
    tick();
    check("stall_en0", 32'(en_decode), 32'h1);
    hold_npc = npc_in;
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_en", 32'(en_decode), 32'h1);
      check("stall_instr", 32'(instr_dout), 32'h2222);
      check("stall_npc", 32'(npc_in), 32'(hold_npc));
    end
    stall_in = 1'b0;
    tick();
    check("stall_done_en", 32'(en_decode), 32'h0);
    check("stall_npc_inc", 32'(npc_in), 32'(hold_npc + 16'd1));

    // Fill to DEPTH with run low, then drain across the pointer wrap
    run = 1'b0;
    for (int i = 0; i < 8; i++) push(16'hA000 + 16'(i), 3'(i), 4'd0);
    check("full_ready", 32'(push_ready), 32'h0);
    check("full_count", 32'(count), 32'h8);
    push_valid = 1'b1; push_instr = 16'hBEEF; push_psr = 3'd7; push_gap = 4'd0;
    tick();
    check("full_reject", 32'(count), 32'h8);
    run = 1'b1;
    tick();
    check("full_pop_reject", 32'(count), 32'h7);
    push_valid = 1'b0;
    wait_idle(40);
    check("full_issues", 32'(issue_count), 32'(exp_issues));

    // Flush mid-GAP with five queued entries
    run = 1'b0;
    push(16'h3333, 3'd1, 4'd6);
    for (int i = 0; i < 5; i++) push(16'h4440 + 16'(i), 3'd2, 4'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check("pre_flush_count", 32'(count), 32'h5);
    check("pre_flush_en", 32'(en_decode), 32'h0);
    flush = 1'b1; flush_npc = 16'h4000;
    push_valid = 1'b1; push_instr = 16'hDEAD; push_psr = 3'd3; push_gap = 4'd0;
    tick();
    flush = 1'b0; push_valid = 1'b0;
    sb.delete();
    exp_npc = 16'h4000;
    check("flush_count", 32'(count), 32'h0);
    check("flush_en", 32'(en_decode), 32'h0);
    check("flush_npc", 32'(npc_in), 32'h4000);
    check("flush_instr", 32'(instr_dout), 32'h0);
    check("flush_psr", 32'(psr), 32'h0);
    check("flush_idle", 32'(idle), 32'h1);
    check("flush_issues", 32'(issue_count), 32'(exp_issues));
    run = 1'b1;
    tick(); tick(); tick();
    check("flush_drop_count", 32'(count), 32'h0);
    check("flush_drop_en", 32'(en_decode), 32'h0);
    push(16'h5555, 3'd6, 4'd0);
    wait_idle(10);
    check("flush_next_npc", 32'(npc_in), 32'h4001);

    // NPC wrap from FFFF to 0000
    flush = 1'b1; flush_npc = 16'hFFFF;
    tick();
    flush = 1'b0;
    exp_npc = 16'hFFFF;
    push(16'h6666, 3'd7, 4'd0);
    push(16'h7777, 3'd0, 4'd0);
    wait_idle(10);
    check("wrap_npc", 32'(npc_in), 32'h0001);
    check("wrap_issues", 32'(issue_count), 32'(exp_issues));

    // Reset in the middle of a stalled issue
    push(16'h8888, 3'd1, 4'd0);
    tick();
    stall_in = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    stall_in = 1'b0;
    reset = 1'b0;
    sb.delete();
    exp_npc = 16'h3000;
    exp_issues = '0;
    check("mid_rst_npc", 32'(npc_in), 32'h3000);
    check("mid_rst_issues", 32'(issue_count), 32'h0);
    check("mid_rst_en", 32'(en_decode), 32'h0);
    check("mid_rst_instr", 32'(instr_dout), 32'h0);
    check("mid_rst_idle", 32'(idle), 32'h1);
    push(16'h9999, 3'd2, 4'd0);
    wait_idle(10);
    check("post_rst_npc", 32'(npc_in), 32'h3001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
